demux1x9_reg: RTL and testbench
===============================

Name: demux1x9_reg

Overview:
Registered 1-to-9 demultiplexer for 5-bit values; the write-side counterpart of the 9-input 5-bit selector used in the datapath.
- One 5-bit value is captured per cycle into one of nine holding slots, chosen by a 4-bit select.
- Each slot has a valid flag, so downstream consumers can tell which slots hold fresh data.
- Select decoding mirrors the selector exactly: codes 0-7 map one-to-one to slots 0-7, and every code >= 8 maps to slot 8.

Parameters:
- WIDTH, 5, data width of the input and of each slot.
- N_SLOT, 9, number of slots (fixed at 9; the select decode depends on it).
- SEL_W, 4, select width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  value to store.
- sel  input  SEL_W  destination slot code.
- wr_en  input  1  write strobe; sampled each rising edge.
- clr_valid  input  1  clears all valid flags (synchronous).
- out_bus  output  N_SLOT*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH].
- valid  output  N_SLOT  per-slot valid flag.
- sel_alias  output  1  sticky; set when a write used a select code of 9-15.
- last_slot  output  SEL_W  index (0-8) of the most recently written slot.

Behaviour:
- Reset (synchronous, active-high, highest priority): out_bus=0, valid=0, sel_alias=0, last_slot=0. Reset asserted mid-stream discards that cycle's write.
- Decode: target = (sel <= 7) ? sel : 8. Codes 9-15 write slot 8 and set sel_alias. sel_alias stays set until reset.
- Write (wr_en=1): at the next rising edge, slot[target] <= in_data, valid[target] <= 1, last_slot <= target. Latency is 1 cycle; outputs are registered only, with no combinational path from inputs to outputs.
- Non-target slots keep their data and valid flags.
- wr_en=0: no state change, except clr_valid as below.
- clr_valid=1: all valid bits go to 0 at the next edge. Data in the slots is retained, not zeroed.
- clr_valid and wr_en in the same cycle: every valid bit is cleared except valid[target], which ends at 1 and holds the new data.
- Back-to-back writes to the same slot: the later value overwrites the earlier one, one per cycle, with no stall.
- in_data and sel are don't-care while wr_en=0.
- There is no FSM; the state is the slot registers, the valid vector, sel_alias and last_slot.

Optional Feature:
Macro DEMUX1X9_PROTECT_EN.
- Defined:
  - A write to a slot whose valid bit is already 1 is refused; data and last_slot are unchanged.
  - An extra output, collision (1 bit, reset 0), pulses high for exactly one cycle after each refused write.
  - If clr_valid and wr_en arrive in the same cycle, the write is accepted regardless of the old valid bit.
- Undefined: writes always overwrite, and the collision port does not exist.

Decomposition:
- Shared package: DEMUX_WIDTH=5, DEMUX_N_SLOT=9, DEMUX_SEL_W=4, DEMUX_LAST_SLOT=8. The selector and this block share the same constants.
- One natural sub-module, dec4x9_onehot: combinational map from sel to a 9-bit one-hot write vector plus an alias flag (sel > 8). Storage and valid logic stay in the top module.

Test Plan:
- Reset, then write 5'h11 to sel=3 -> next cycle: slot3=5'h11, valid=9'b000001000, last_slot=3, all other slots 0.
- Write 5'h1F with sel=12 -> slot8=5'h1F, valid[8]=1, sel_alias=1, last_slot=8. Then write sel=8 with 5'h02 -> slot8=5'h02, sel_alias still 1.
- Fill slots 0-8 with values k+1, then pulse clr_valid -> valid=0 and all slot data unchanged.
- clr_valid with wr_en to sel=5, in_data=5'h0A, all slots valid beforehand -> valid=9'b000100000, slot5=5'h0A.
- Write 5'h07 to sel=1, then assert reset in the same cycle as a write of 5'h09 to sel=2 -> all outputs 0 after reset; slot2 not written.
- With DEMUX1X9_PROTECT_EN defined: write 5'h04 then 5'h05 to sel=0 -> slot0 stays 5'h04 and collision is high for one cycle. Without the macro: slot0=5'h05.

Source files
------------

// File: rtl/demux1x9_reg_pkg.sv
// Shared constants and select decode for the 9-way selector/demux pair.
package demux1x9_reg_pkg;

  localparam int DEMUX_WIDTH     = 5;
  localparam int DEMUX_N_SLOT    = 9;
  localparam int DEMUX_SEL_W     = 4;
  localparam int DEMUX_LAST_SLOT = 8;

  // Codes 0-7 are direct, everything above folds onto the last slot.
  function automatic logic [DEMUX_SEL_W-1:0] target_of(input logic [DEMUX_SEL_W-1:0] s);
    return (s <= DEMUX_SEL_W'(7)) ? s : DEMUX_SEL_W'(DEMUX_LAST_SLOT);
  endfunction

endpackage

// File: rtl/demux1x9_reg_dec4x9_onehot.sv
// Combinational select decode: 4-bit code to 9-bit one-hot plus alias flag.
module dec4x9_onehot
  import demux1x9_reg_pkg::*;
(
  input  logic [DEMUX_SEL_W-1:0]  sel,
  output logic [DEMUX_N_SLOT-1:0] onehot,
  output logic                    sel_hi
);

  logic [DEMUX_SEL_W-1:0] target;

  always_comb begin
    target = target_of(sel);
    onehot = '0;
    for (int k = 0; k < DEMUX_N_SLOT; k++) begin
      onehot[k] = (target == DEMUX_SEL_W'(k));
    end
    sel_hi = (sel > DEMUX_SEL_W'(DEMUX_LAST_SLOT));
  end

endmodule

// File: rtl/demux1x9_reg.sv
// Registered 1-to-9 demultiplexer with per-slot valid flags.
// Optional write protection of valid slots: define DEMUX1X9_PROTECT_EN.
module demux1x9_reg
  import demux1x9_reg_pkg::*;
#(
  parameter int WIDTH  = DEMUX_WIDTH,
  parameter int N_SLOT = DEMUX_N_SLOT,
  parameter int SEL_W  = DEMUX_SEL_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      wr_en,
  input  logic                      clr_valid,
  output logic [N_SLOT*WIDTH-1:0]   out_bus,
  output logic [N_SLOT-1:0]         valid,
  output logic                      sel_alias,
  output logic [SEL_W-1:0]          last_slot
`ifdef DEMUX1X9_PROTECT_EN
  ,
  output logic                      collision
`endif
);

  logic [N_SLOT-1:0]            onehot;
  logic                         sel_hi;
  logic                         wr_go;
  logic [N_SLOT-1:0][WIDTH-1:0] data_p1;
  logic [N_SLOT-1:0]            vld_p1;
  logic                         alias_p1;
  logic [SEL_W-1:0]             last_p1;

  dec4x9_onehot u_dec (
    .sel    (sel),
    .onehot (onehot),
    .sel_hi (sel_hi)
  );

`ifdef DEMUX1X9_PROTECT_EN
  logic hit;
  logic coll_p1;

  // A same-cycle clear frees the target slot, so the write goes through.
  assign hit   = |(onehot & vld_p1);
  assign wr_go = wr_en & (clr_valid | ~hit);

  always_ff @(posedge clk) begin
    if (reset) coll_p1 <= 1'b0;
    else       coll_p1 <= wr_en & ~clr_valid & hit;
  end

  assign collision = coll_p1;
`else
  assign wr_go = wr_en;
`endif

  // ---- stage p1: slot storage and status ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1  <= '0;
      vld_p1   <= '0;
      alias_p1 <= 1'b0;
      last_p1  <= '0;
    end else begin
      for (int k = 0; k < N_SLOT; k++) begin
        if (wr_go && onehot[k]) data_p1[k] <= in_data;
      end
      vld_p1 <= (clr_valid ? '0 : vld_p1) | (wr_go ? onehot : '0);
      if (wr_en && sel_hi) alias_p1 <= 1'b1;
      if (wr_go)           last_p1  <= target_of(sel);
    end
  end

  assign out_bus   = data_p1;
  assign valid     = vld_p1;
  assign sel_alias = alias_p1;
  assign last_slot = last_p1;

endmodule

// File: tb/tb_demux1x9_reg.sv
// Directed self-checking bench for demux1x9_reg.
module tb_demux1x9_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_data;
  logic [3:0]  sel;
  logic        wr_en;
  logic        clr_valid;
  logic [44:0] out_bus;
  logic [8:0]  valid;
  logic        sel_alias;
  logic [3:0]  last_slot;
`ifdef DEMUX1X9_PROTECT_EN
  logic        collision;
`endif

  int checks   = 0;
  int failures = 0;
  logic [44:0] exp_bus;

  demux1x9_reg dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .wr_en     (wr_en),
    .clr_valid (clr_valid),
    .out_bus   (out_bus),
    .valid     (valid),
    .sel_alias (sel_alias),
    .last_slot (last_slot)
`ifdef DEMUX1X9_PROTECT_EN
    ,
    .collision (collision)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic rst, input logic we, input logic [3:0] s,
                     input logic [4:0] d, input logic clr);
    reset = rst; wr_en = we; sel = s; in_data = d; clr_valid = clr;
    @(posedge clk); #1;
    reset = 1'b0; wr_en = 1'b0; clr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; clr_valid = 1'b0; sel = '0; in_data = '0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 4'd0, 5'h00, 1'b0);
    chk("rst_bus",   64'(out_bus),   64'd0);
    chk("rst_valid", 64'(valid),     64'd0);
    chk("rst_alias", 64'(sel_alias), 64'd0);
    chk("rst_last",  64'(last_slot), 64'd0);

    cyc(1'b0, 1'b1, 4'd3, 5'h11, 1'b0);
    chk("w3_bus",   64'(out_bus),   64'(45'h11) << 15);
    chk("w3_valid", 64'(valid),     64'(9'b000001000));
    chk("w3_last",  64'(last_slot), 64'd3);

    cyc(1'b0, 1'b1, 4'd7, 5'h15, 1'b0);
    chk("w7_slot",  64'(out_bus[35 +: 5]), 64'h15);
    chk("w7_alias", 64'(sel_alias),        64'd0);

    cyc(1'b0, 1'b1, 4'd12, 5'h1F, 1'b0);
    chk("w12_slot8", 64'(out_bus[40 +: 5]), 64'h1F);
    chk("w12_valid", 64'(valid),            64'(9'b110001000));
    chk("w12_alias", 64'(sel_alias),        64'd1);
    chk("w12_last",  64'(last_slot),        64'd8);

    cyc(1'b0, 1'b1, 4'd8, 5'h02, 1'b0);
    chk("w8_slot8", 64'(out_bus[40 +: 5]), 64'h02);
    chk("w8_alias", 64'(sel_alias),        64'd1);

    // fill all slots with k+1
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0, 1'b1, 4'(k), 5'(k + 1), 1'b0);
      exp_bus[k*5 +: 5] = 5'(k + 1);
    end
    chk("fill_bus",   64'(out_bus),   64'(exp_bus));
    chk("fill_valid", 64'(valid),     64'h1FF);
    chk("fill_last",  64'(last_slot), 64'd8);

    cyc(1'b0, 1'b0, 4'd2, 5'h1E, 1'b1);
    chk("clr_valid", 64'(valid),   64'd0);
    chk("clr_bus",   64'(out_bus), 64'(exp_bus));

    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 4'(k), 5'(k + 1), 1'b0);
    cyc(1'b0, 1'b1, 4'd5, 5'h0A, 1'b1);
    exp_bus[25 +: 5] = 5'h0A;
    chk("clrwr_valid", 64'(valid),     64'(9'b000100000));
    chk("clrwr_bus",   64'(out_bus),   64'(exp_bus));
    chk("clrwr_last",  64'(last_slot), 64'd5);

    cyc(1'b0, 1'b0, 4'd4, 5'h1B, 1'b0);
    chk("idle_bus",   64'(out_bus), 64'(exp_bus));
    chk("idle_valid", 64'(valid),   64'(9'b000100000));

    cyc(1'b0, 1'b1, 4'd1, 5'h07, 1'b0);
    chk("w1_slot", 64'(out_bus[5 +: 5]), 64'h07);
    cyc(1'b1, 1'b1, 4'd2, 5'h09, 1'b0);
    chk("rstwr_bus",   64'(out_bus),   64'd0);
    chk("rstwr_valid", 64'(valid),     64'd0);
    chk("rstwr_alias", 64'(sel_alias), 64'd0);
    chk("rstwr_last",  64'(last_slot), 64'd0);

    cyc(1'b0, 1'b1, 4'd9, 5'h03, 1'b0);
    chk("w9_slot8", 64'(out_bus[40 +: 5]), 64'h03);
    chk("w9_alias", 64'(sel_alias),        64'd1);

    cyc(1'b0, 1'b1, 4'd0, 5'h04, 1'b0);
    chk("p_first", 64'(out_bus[0 +: 5]), 64'h04);
    cyc(1'b0, 1'b1, 4'd0, 5'h05, 1'b0);
`ifdef DEMUX1X9_PROTECT_EN
    chk("p_second", 64'(out_bus[0 +: 5]), 64'h04);
    chk("p_coll",   64'(collision),       64'd1);
    cyc(1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
    chk("p_coll_end", 64'(collision), 64'd0);
`else
    chk("p_second", 64'(out_bus[0 +: 5]), 64'h05);
`endif
    cyc(1'b0, 1'b1, 4'd0, 5'h06, 1'b1);
    chk("p_clrwr_slot",  64'(out_bus[0 +: 5]), 64'h06);
    chk("p_clrwr_valid", 64'(valid),           64'(9'b000000001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
